// File: rtl/ccu_req_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among NumPorts cores.
// One transaction in flight; priority rotates past the owner after each response.
module ccu_req_arbiter #(
  parameter int NumPorts  = 2,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0]                 req_valid_i,
  output logic [NumPorts-1:0]                 req_ready_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumPorts-1:0]                 req_we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata_i,
  output logic [NumPorts-1:0]                 rsp_valid_o,
  input  logic [NumPorts-1:0]                 rsp_ready_i,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                mem_req_valid_o,
  input  logic                                mem_req_ready_i,
  output logic [AddrWidth-1:0]                mem_req_addr_o,
  output logic                                mem_req_we_o,
  output logic [DataWidth-1:0]                mem_req_wdata_o,
  input  logic                                mem_rsp_valid_i,
  output logic                                mem_rsp_ready_o,
  input  logic [DataWidth-1:0]                mem_rsp_rdata_i,
  output logic                                busy_o,
  output logic [$clog2(NumPorts)-1:0]         owner_o
);
  localparam int IdxW = $clog2(NumPorts);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  logic [IdxW-1:0]       ptr, owner, win, ptr_nxt;
  logic                  found;
  logic [AddrWidth-1:0]  addr_q;
  logic                  we_q;
  logic [DataWidth-1:0]  wdata_q;

  // First valid at or after ptr, wrapping modulo NumPorts.
  always_comb begin
    logic [IdxW-1:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NumPorts; k++) begin
      cand = IdxW'((int'(ptr) + k) % NumPorts);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign ptr_nxt = (owner == IdxW'(NumPorts - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          addr_q  <= req_addr_i[win];
          we_q    <= req_we_i[win];
          wdata_q <= req_wdata_i[win];
          owner   <= win;
          state   <= ISSUE;
        end
        ISSUE: if (mem_req_ready_i) state <= WAIT;
        WAIT: if (mem_rsp_valid_i && rsp_ready_i[owner]) begin
          ptr   <= ptr_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    assign req_ready_o[i] = (state == IDLE) && found && (win == IdxW'(i));
    assign rsp_valid_o[i] = (state == WAIT) && mem_rsp_valid_i && (owner == IdxW'(i));
  end

  assign rsp_rdata_o     = mem_rsp_rdata_i;
  assign mem_req_valid_o = (state == ISSUE);
  assign mem_req_addr_o  = addr_q;
  assign mem_req_we_o    = we_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_rsp_ready_o = (state == WAIT) && rsp_ready_i[owner];
  assign busy_o          = (state != IDLE);
  assign owner_o         = owner;

endmodule

// File: tb/tb_ccu_req_arbiter.sv
// Directed bench for ccu_req_arbiter: a 2-port instance for the main scenarios
// and a 4-port instance for the pointer wrap case.
module tb_ccu_req_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // 2-port instance
  logic [1:0]         a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
  logic [1:0][AW-1:0] a_req_addr;
  logic [1:0][DW-1:0] a_req_wdata;
  logic [DW-1:0]      a_rsp_rdata, a_mreq_wdata, a_mrsp_rdata;
  logic [AW-1:0]      a_mreq_addr;
  logic               a_mreq_valid, a_mreq_ready, a_mreq_we, a_mrsp_valid, a_mrsp_ready, a_busy;
  logic [0:0]         a_owner;

  // 4-port instance
  logic [3:0]         b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
  logic [3:0][AW-1:0] b_req_addr;
  logic [3:0][DW-1:0] b_req_wdata;
  logic [DW-1:0]      b_rsp_rdata, b_mreq_wdata, b_mrsp_rdata;
  logic [AW-1:0]      b_mreq_addr;
  logic               b_mreq_valid, b_mreq_ready, b_mreq_we, b_mrsp_valid, b_mrsp_ready, b_busy;
  logic [1:0]         b_owner;

  ccu_req_arbiter #(.NumPorts(2), .AddrWidth(AW), .DataWidth(DW)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
    .req_we_i(a_req_we), .req_wdata_i(a_req_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
    .mem_req_valid_o(a_mreq_valid), .mem_req_ready_i(a_mreq_ready),
    .mem_req_addr_o(a_mreq_addr), .mem_req_we_o(a_mreq_we), .mem_req_wdata_o(a_mreq_wdata),
    .mem_rsp_valid_i(a_mrsp_valid), .mem_rsp_ready_o(a_mrsp_ready), .mem_rsp_rdata_i(a_mrsp_rdata),
    .busy_o(a_busy), .owner_o(a_owner)
  );

  ccu_req_arbiter #(.NumPorts(4), .AddrWidth(AW), .DataWidth(DW)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
    .req_we_i(b_req_we), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .mem_req_valid_o(b_mreq_valid), .mem_req_ready_i(b_mreq_ready),
    .mem_req_addr_o(b_mreq_addr), .mem_req_we_o(b_mreq_we), .mem_req_wdata_o(b_mreq_wdata),
    .mem_rsp_valid_i(b_mrsp_valid), .mem_rsp_ready_o(b_mrsp_ready), .mem_rsp_rdata_i(b_mrsp_rdata),
    .busy_o(b_busy), .owner_o(b_owner)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = '0;
    a_mreq_ready = 1'b0; a_mrsp_valid = 1'b0; a_mrsp_rdata = '0;
    b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = '0;
    b_mreq_ready = 1'b0; b_mrsp_valid = 1'b0; b_mrsp_rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_mreq_valid", a_mreq_valid, 0);
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_mrsp_ready", a_mrsp_ready, 0);
    chk("rst_owner", a_owner, 0);
    chk("rst_addr", a_mreq_addr, 0);
    chk("rst_wdata", a_mreq_wdata, 0);

    // Single read from core 1
    step();
    a_req_valid = 2'b10; a_req_addr[1] = 64'h8000_0000; a_req_we[1] = 1'b0;
    #1;
    chk("rd_req_ready", a_req_ready, 2'b10);
    step();
    a_req_valid = 2'b00;
    #1;
    chk("rd_mreq_valid", a_mreq_valid, 1);
    chk("rd_mreq_addr", a_mreq_addr, 64'h8000_0000);
    chk("rd_mreq_we", a_mreq_we, 0);
    chk("rd_owner", a_owner, 1);
    chk("rd_busy", a_busy, 1);
    a_mreq_ready = 1'b1;
    step();
    a_mreq_ready = 1'b0; a_rsp_ready = 2'b11;
    #1;
    chk("rd_wait_rsp_valid", a_rsp_valid, 0);
    step();
    step();
    a_mrsp_valid = 1'b1; a_mrsp_rdata = 64'hDEAD_BEEF;
    #1;
    chk("rd_rsp_valid", a_rsp_valid, 2'b10);
    chk("rd_rsp_rdata", a_rsp_rdata, 64'hDEAD_BEEF);
    chk("rd_mrsp_ready", a_mrsp_ready, 1);
    step();
    a_mrsp_valid = 1'b0; a_rsp_ready = 2'b00;
    #1;
    chk("rd_done_busy", a_busy, 0);

    // Fairness: both cores request continuously, ptr starts at 0
    a_req_valid = 2'b11; a_req_we = 2'b00;
    a_req_addr[0] = 64'h100; a_req_addr[1] = 64'h200;
    for (int t = 0; t < 6; t++) begin
      #1;
      chk("fair_grant", a_req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("fair_owner", a_owner, t % 2);
      chk("fair_addr", a_mreq_addr, (t % 2 == 0) ? 64'h100 : 64'h200);
      a_mreq_ready = 1'b1;
      step();
      a_mreq_ready = 1'b0; a_mrsp_valid = 1'b1; a_rsp_ready = 2'b11;
      #1;
      chk("fair_rsp_valid", a_rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      step();
      a_mrsp_valid = 1'b0; a_rsp_ready = 2'b00;
    end
    a_req_valid = 2'b00;
    #1;

    // Backpressure on core 0 write with core 1 pending
    a_req_valid = 2'b11; a_req_we = 2'b01;
    a_req_addr[0] = 64'h10; a_req_wdata[0] = 64'h1234;
    a_req_addr[1] = 64'h20; a_req_wdata[1] = 64'h0;
    #1;
    chk("bp_grant", a_req_ready, 2'b01);
    step();
    a_req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_mreq_valid", a_mreq_valid, 1);
      chk("bp_addr", a_mreq_addr, 64'h10);
      chk("bp_we", a_mreq_we, 1);
      chk("bp_wdata", a_mreq_wdata, 64'h1234);
      chk("bp_req_ready", a_req_ready, 0);
      step();
    end
    a_mreq_ready = 1'b1;
    step();
    a_mreq_ready = 1'b0;

    // Response stall with owner's ready low
    a_mrsp_valid = 1'b1; a_rsp_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_mrsp_ready", a_mrsp_ready, 0);
      chk("stall_rsp_valid", a_rsp_valid, 2'b01);
      chk("stall_busy", a_busy, 1);
      chk("stall_req_ready", a_req_ready, 0);
      step();
    end
    a_rsp_ready = 2'b11;
    #1;
    chk("stall_release", a_mrsp_ready, 1);
    step();
    a_mrsp_valid = 1'b0; a_rsp_ready = 2'b00;
    #1;
    chk("bp_core1_grant", a_req_ready, 2'b10);

    // Accept core 1, reset while in WAIT
    step();
    a_req_valid = 2'b00;
    a_mreq_ready = 1'b1;
    step();
    a_mreq_ready = 1'b0;
    #1;
    chk("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("wrst_busy", a_busy, 0);
    chk("wrst_mreq_valid", a_mreq_valid, 0);
    chk("wrst_owner", a_owner, 0);
    chk("wrst_addr", a_mreq_addr, 0);
    chk("wrst_we", a_mreq_we, 0);
    chk("wrst_req_ready", a_req_ready, 0);
    chk("wrst_rsp_valid", a_rsp_valid, 0);
    chk("wrst_mrsp_ready", a_mrsp_ready, 0);
    // ptr must be back at 0: with both valid, core 0 wins
    a_req_valid = 2'b11;
    #1;
    chk("wrst_ptr", a_req_ready, 2'b01);
    a_req_valid = 2'b10; a_req_addr[1] = 64'h3000; a_req_we = 2'b00;
    #1;
    chk("wrst_core1_ready", a_req_ready, 2'b10);
    step();
    a_req_valid = 2'b00;
    #1;
    chk("wrst_core1_addr", a_mreq_addr, 64'h3000);
    chk("wrst_core1_owner", a_owner, 1);

    // 4-port wrap: core 2 transaction moves ptr to 3
    b_req_valid = 4'b0100; b_req_addr[2] = 64'h22; b_req_addr[0] = 64'h11;
    #1;
    chk("w4_first", b_req_ready, 4'b0100);
    step();
    b_req_valid = 4'b0000; b_mreq_ready = 1'b1;
    step();
    b_mreq_ready = 1'b0; b_mrsp_valid = 1'b1; b_rsp_ready = 4'b1111;
    step();
    b_mrsp_valid = 1'b0;
    b_req_valid = 4'b0101;
    #1;
    chk("w4_wrap_grant", b_req_ready, 4'b0001);
    step();
    b_req_valid = 4'b0100;
    #1;
    chk("w4_owner0", b_owner, 0);
    chk("w4_addr0", b_mreq_addr, 64'h11);
    b_mreq_ready = 1'b1;
    step();
    b_mreq_ready = 1'b0; b_mrsp_valid = 1'b1;
    #1;
    chk("w4_rsp0", b_rsp_valid, 4'b0001);
    step();
    b_mrsp_valid = 1'b0;
    #1;
    chk("w4_second_grant", b_req_ready, 4'b0100);
    step();
    b_req_valid = 4'b0000;
    #1;
    chk("w4_owner2", b_owner, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
